// File: rtl/button_conditioner_pkg.sv
// btn_pkg: button index map and default cycle constants for button_conditioner.
package btn_pkg;
    localparam int BTN_SALUD      = 0;
    localparam int BTN_ENERGIA    = 1;
    localparam int BTN_HAMBRE     = 2;
    localparam int BTN_DIVERSION  = 3;
    localparam int BTN_RESET      = 4;
    localparam int BTN_TEST       = 5;
    localparam int DEF_N_BTN      = 6;
    localparam int DEF_DEB_CYC    = 1_000_000;
    localparam int DEF_LONG_CYC   = 250_000_000;
    localparam int DEF_REPEAT_CYC = 12_500_000;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: bundle of raw button inputs and conditioned outputs.
interface button_conditioner_if #(parameter int N_BTN = 6);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_long;
    modport master (output btn_raw, input btn_level, btn_press, btn_long);
    modport slave (input btn_raw, output btn_level, btn_press, btn_long);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button -- 2-flop synchronizer, debounce counter, level and press pulse.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    localparam int W = cnt_w(DEB_CYC);
    logic [1:0]   r_sync;
    logic [W-1:0] r_cnt;
    logic         r_level;
    logic         r_press;
    logic         w_diff;
    logic         w_done;
    assign w_diff = (~r_sync[1]) != r_level;
    assign w_done = w_diff && (r_cnt == W'(DEB_CYC - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_cnt   <= (w_diff && !w_done) ? r_cnt + W'(1) : '0;
            r_level <= r_level ^ w_done;
            r_press <= w_done && !r_level;
        end
    end
    assign btn_level = r_level;
    assign btn_press = r_press;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced levels, press pulses and long-press pulses for the board buttons.
// Optional auto-repeat on bits 0-3 when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_long
);
    localparam int LW = cnt_w(LONG_CYC);
    localparam int RW = cnt_w(REPEAT_CYC);
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_rep;
    if (DEB_CYC < 1 || LONG_CYC < 2 || REPEAT_CYC < 1 || RW < 1) begin : g_bad_cfg
        $error("button_conditioner: cycle parameters out of range");
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_press(w_press[i])
        );
        if (i == BTN_RESET || i == BTN_TEST) begin : g_long
            logic [LW-1:0] r_hold;
            logic          r_long;
            // hold count saturates at LONG_CYC-1 so the pulse fires once per press
            always_ff @(posedge clk) begin
                if (reset || !btn_level[i]) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_hold <= (r_hold == LW'(LONG_CYC - 1)) ? r_hold : r_hold + LW'(1);
                    r_long <= r_hold == LW'(LONG_CYC - 2);
                end
            end
            assign btn_long[i] = r_long;
            assign w_rep[i]    = 1'b0;
        end else begin : g_short
            assign btn_long[i] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            logic [RW-1:0] r_rcnt;
            logic          r_rep;
            always_ff @(posedge clk) begin
                if (reset || !btn_level[i]) begin
                    r_rcnt <= '0;
                    r_rep  <= 1'b0;
                end else begin
                    r_rcnt <= (r_rcnt == RW'(REPEAT_CYC - 1)) ? '0 : r_rcnt + RW'(1);
                    r_rep  <= r_rcnt == RW'(REPEAT_CYC - 1);
                end
            end
            assign w_rep[i] = r_rep;
`else
            assign w_rep[i] = 1'b0;
`endif
        end
    end
    // a repeat landing on the release edge is masked by the falling level
    assign btn_press = w_press | (w_rep & btn_level);
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with short cycle parameters.
module tb_button_conditioner;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    typedef struct {
        int         c;
        logic [5:0] l;
        logic [5:0] p;
        logic [5:0] g;
    } ev_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst_q = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         t;
    int         a;
    logic [5:0] prev_level = '0;
    ev_t        q[$];
    button_conditioner_if #(.N_BTN(6)) bus ();
    button_conditioner #(
        .N_BTN(6), .DEB_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (bus.btn_raw),
        .btn_level(bus.btn_level),
        .btn_press(bus.btn_press),
        .btn_long (bus.btn_long)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
        end
    endtask
    task automatic push(input int c, input logic [5:0] l, input logic [5:0] p, input logic [5:0] g);
        ev_t e;
        e.c = c;
        e.l = l;
        e.p = p;
        e.g = g;
        q.push_back(e);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // monitor: any level change or pulse must match the head of the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (rst_q) begin
            chk("reset_outputs", {14'd0, bus.btn_level, bus.btn_press, bus.btn_long}, 32'd0);
        end else if (bus.btn_level != prev_level || |bus.btn_press || |bus.btn_long) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event at cycle %0d: level=%h press=%h long=%h expected no event",
                         cyc, bus.btn_level, bus.btn_press, bus.btn_long);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.c);
                chk("event_level", {26'd0, bus.btn_level}, {26'd0, e.l});
                chk("event_press", {26'd0, bus.btn_press}, {26'd0, e.p});
                chk("event_long", {26'd0, bus.btn_long}, {26'd0, e.g});
            end
        end
        prev_level = bus.btn_level;
    end
    initial begin
        bus.btn_raw = '1;
        tick(3);
        reset = 1'b0;
        tick(3);
        // clean press/release of bit 0
        t = cyc;
        a = t + 2 + DEB;
        bus.btn_raw[0] = 1'b0;
        push(a, 6'h01, 6'h01, 6'h00);
        push(a + 7, 6'h00, 6'h00, 6'h00);
        tick(7);
        bus.btn_raw[0] = 1'b1;
        tick(12);
        // bit 2 bouncing every 2 cycles must never be accepted
        for (int k = 0; k < 5; k++) begin
            bus.btn_raw[2] = 1'b0;
            tick(2);
            bus.btn_raw[2] = 1'b1;
            tick(2);
        end
        tick(8);
        chk("bounce_level", {31'd0, bus.btn_level[2]}, 32'd0);
        // bit 4 held 30 cycles past acceptance: one long pulse 19 cycles after the press
        t = cyc;
        a = t + 6;
        bus.btn_raw[4] = 1'b0;
        push(a, 6'h10, 6'h10, 6'h00);
        push(a + 19, 6'h10, 6'h00, 6'h10);
        push(a + 30, 6'h00, 6'h00, 6'h00);
        tick(30);
        bus.btn_raw[4] = 1'b1;
        tick(12);
        // bit 4 held only 10 cycles: press, no long
        t = cyc;
        a = t + 6;
        bus.btn_raw[4] = 1'b0;
        push(a, 6'h10, 6'h10, 6'h00);
        push(a + 10, 6'h00, 6'h00, 6'h00);
        tick(10);
        bus.btn_raw[4] = 1'b1;
        tick(12);
        // reset at debounce count 2 of bit 1, button held through it
        bus.btn_raw[1] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        a = cyc + 6;
        push(a, 6'h02, 6'h02, 6'h00);
        push(a + 7, 6'h00, 6'h00, 6'h00);
        tick(7);
        bus.btn_raw[1] = 1'b1;
        tick(12);
        // bit 3 held 30 cycles: repeats only with auto-repeat built in
        t = cyc;
        a = t + 6;
        bus.btn_raw[3] = 1'b0;
        push(a, 6'h08, 6'h08, 6'h00);
`ifdef BTN_AUTOREPEAT_EN
        push(a + 8, 6'h08, 6'h08, 6'h00);
        push(a + 16, 6'h08, 6'h08, 6'h00);
        push(a + 24, 6'h08, 6'h08, 6'h00);
`endif
        push(a + 30, 6'h00, 6'h00, 6'h00);
        tick(30);
        bus.btn_raw[3] = 1'b1;
        tick(12);
        // bit 5 held 30 cycles: single press, one long, never repeats
        t = cyc;
        a = t + 6;
        bus.btn_raw[5] = 1'b0;
        push(a, 6'h20, 6'h20, 6'h00);
        push(a + 19, 6'h20, 6'h00, 6'h20);
        push(a + 30, 6'h00, 6'h00, 6'h00);
        tick(30);
        bus.btn_raw[5] = 1'b1;
        tick(12);
        // bits 0 and 5 pressed together
        t = cyc;
        a = t + 6;
        bus.btn_raw[0] = 1'b0;
        bus.btn_raw[5] = 1'b0;
        push(a, 6'h21, 6'h21, 6'h00);
        push(a + 7, 6'h00, 6'h00, 6'h00);
        tick(7);
        bus.btn_raw[0] = 1'b1;
        bus.btn_raw[5] = 1'b1;
        tick(12);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
